// File: rtl/stage_id_pipe.sv
// Instruction-decode stage: register file, opcode decode, load-use interlock and the ID/EX register.
// Optional same-cycle write-back bypass into the captured read data is enabled with `define ID_WB_BYPASS_EN.
module stage_id_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] PCAddResult_in,
    input  logic [31:0]       Instruction,
    input  logic              InValid,
    input  logic [REG_AW-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite_in,
    input  logic              Stall_in,
    input  logic              Flush,
    output logic              OutValid,
    output logic              RegWrite_out,
    output logic              MemtoReg,
    output logic              Branch,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegDst,
    output logic              ALUSrc,
    output logic [5:0]        ALUOp,
    output logic [DATA_W-1:0] PCAddResult_out,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] SignExtResult,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic              Stall_out
);

    // Handshake: InValid qualifies Instruction/PCAddResult_in. Stall_out is the back-pressure
    // answer: while it is high, upstream must hold PC and Instruction unchanged for another cycle.

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              reg_dst;
        logic              alu_src;
        logic [5:0]        alu_op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sext;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } idex_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    idex_t             idex_q;
    idex_t             idex_d;
    idex_t             dec;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs_in;
    logic [REG_AW-1:0] rt_in;
    logic [REG_AW-1:0] rd_in;
    logic              wb_en;
    logic              uses_rt;
    logic              load_use;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign opcode = Instruction[31:26];
    assign rs_in  = Instruction[21 +: REG_AW];
    assign rt_in  = Instruction[16 +: REG_AW];
    assign rd_in  = Instruction[11 +: REG_AW];
    assign wb_en  = RegWrite_in && (WriteRegister != '0);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[WriteRegister] = WriteData;
        end
    end

    always_comb begin
        rd1 = rf_q[rs_in];
        rd2 = rf_q[rt_in];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (WriteRegister == rs_in)) rd1 = WriteData;
        if (wb_en && (WriteRegister == rt_in)) rd2 = WriteData;
`endif
    end

    always_comb begin
        dec        = '0;
        dec.valid  = InValid;
        dec.alu_op = opcode;
        dec.pc     = PCAddResult_in;
        dec.rd1    = rd1;
        dec.rd2    = rd2;
        dec.sext   = {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};
        dec.rs     = rs_in;
        dec.rt     = rt_in;
        dec.rd     = rd_in;
        case (opcode)
            OP_R:    begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            OP_LW:   begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
            end
            OP_SW:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
            OP_BEQ:  dec.branch = 1'b1;
            OP_ADDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            default: ;
        endcase
    end

    // Only R-type, sw and beq actually consume rt as a source operand.
    assign uses_rt  = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign load_use = idex_q.valid && idex_q.mem_read && (idex_q.rt != '0) && InValid &&
                      ((idex_q.rt == rs_in) || (uses_rt && (idex_q.rt == rt_in)));

    always_comb begin
        idex_d = idex_q;
        if (!Stall_in) begin
            idex_d = dec;
            if (Flush || load_use || !InValid) begin
                idex_d.valid      = 1'b0;
                idex_d.reg_write  = 1'b0;
                idex_d.mem_to_reg = 1'b0;
                idex_d.branch     = 1'b0;
                idex_d.mem_read   = 1'b0;
                idex_d.mem_write  = 1'b0;
                idex_d.reg_dst    = 1'b0;
                idex_d.alu_src    = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idex_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            idex_q <= idex_d;
            rf_q   <= rf_d;
        end
    end

    // Gated by Reset so an asserted reset drops a pending stall immediately.
    assign Stall_out = Reset && (Stall_in || (load_use && !Flush));

    assign OutValid        = idex_q.valid;
    assign RegWrite_out    = idex_q.reg_write;
    assign MemtoReg        = idex_q.mem_to_reg;
    assign Branch          = idex_q.branch;
    assign MemRead         = idex_q.mem_read;
    assign MemWrite        = idex_q.mem_write;
    assign RegDst          = idex_q.reg_dst;
    assign ALUSrc          = idex_q.alu_src;
    assign ALUOp           = idex_q.alu_op;
    assign PCAddResult_out = idex_q.pc;
    assign ReadData1       = idex_q.rd1;
    assign ReadData2       = idex_q.rd2;
    assign SignExtResult   = idex_q.sext;
    assign rs              = idex_q.rs;
    assign rt              = idex_q.rt;
    assign rd              = idex_q.rd;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: decode table plus hazard, stall-priority, bypass and reset sequences.
// Expectations for the bypass case follow whether ID_WB_BYPASS_EN is defined for the build.
module tb_stage_id_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // ctrl word order: {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R    = 7'b1000010;
    localparam logic [6:0] C_LW   = 7'b1101001;
    localparam logic [6:0] C_SW   = 7'b0000101;
    localparam logic [6:0] C_BEQ  = 7'b0010000;
    localparam logic [6:0] C_ADDI = 7'b1000001;

    logic              Clk;
    logic              Reset;
    logic [DATA_W-1:0] PCAddResult_in;
    logic [31:0]       Instruction;
    logic              InValid;
    logic [REG_AW-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite_in;
    logic              Stall_in;
    logic              Flush;
    logic              OutValid, RegWrite_out, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc;
    logic [5:0]        ALUOp;
    logic [DATA_W-1:0] PCAddResult_out, ReadData1, ReadData2, SignExtResult;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              Stall_out;
    logic [6:0]        act_ctrl;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic        in_valid;
        logic [6:0]  ctrl;
        logic [5:0]  alu_op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
    } vec_t;

    vec_t vecs[7];

    stage_id_pipe #(.DATA_W(DATA_W), .NREGS(32)) dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult_in(PCAddResult_in), .Instruction(Instruction),
        .InValid(InValid), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite_in(RegWrite_in), .Stall_in(Stall_in), .Flush(Flush), .OutValid(OutValid),
        .RegWrite_out(RegWrite_out), .MemtoReg(MemtoReg), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .PCAddResult_out(PCAddResult_out), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .SignExtResult(SignExtResult), .rs(rs), .rt(rt), .rd(rd), .Stall_out(Stall_out)
    );

    assign act_ctrl = {RegWrite_out, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc};

    // Clock and reset.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
        $fatal(1);
    end

    function automatic logic [31:0] enc_r(logic [4:0] s, logic [4:0] t, logic [4:0] d);
        return {6'b000000, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h req=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(logic [31:0] instr, logic v);
        Instruction = instr;
        InValid     = v;
    endtask

    task automatic write_reg(logic [4:0] a, logic [31:0] d);
        WriteRegister = a;
        WriteData     = d;
        RegWrite_in   = 1'b1;
        tick();
        RegWrite_in   = 1'b0;
    endtask

    task automatic lw_then(string nm, logic [31:0] nxt, logic exp_stall, logic [4:0] lw_rt);
        drive(enc_i(6'h23, 5'd1, lw_rt, 16'd8), 1'b1);
        tick();
        drive(nxt, 1'b1);
        #1;
        chk({nm, "_stall"}, Stall_out, exp_stall);
        tick();
        chk({nm, "_valid_first"}, OutValid, !exp_stall);
        if (exp_stall) begin
            chk({nm, "_bubble_ctrl"}, act_ctrl, C_NONE);
            #1;
            chk({nm, "_stall_released"}, Stall_out, 1'b0);
            tick();
            chk({nm, "_valid_after"}, OutValid, 1'b1);
        end
        chk({nm, "_rs"}, rs, nxt[25:21]);
        drive(32'd0, 1'b0);
        tick();
    endtask

    initial begin
        Reset = 1'b1; PCAddResult_in = '0; Instruction = '0; InValid = 1'b0;
        WriteRegister = '0; WriteData = '0; RegWrite_in = 1'b0; Stall_in = 1'b0; Flush = 1'b0;

        vecs[0] = '{enc_r(5'd1, 5'd2, 5'd6),              1'b1, C_R,    6'h00, 32'h100, 32'h200, 32'h0000_3020};
        vecs[1] = '{enc_i(6'h23, 5'd1, 5'd8, 16'h0004),   1'b1, C_LW,   6'h23, 32'h100, 32'h000, 32'h0000_0004};
        vecs[2] = '{enc_i(6'h2B, 5'd2, 5'd3, 16'hFFFC),   1'b1, C_SW,   6'h2B, 32'h200, 32'h300, 32'hFFFF_FFFC};
        vecs[3] = '{enc_i(6'h04, 5'd4, 5'd5, 16'h0010),   1'b1, C_BEQ,  6'h04, 32'h444, 32'h555, 32'h0000_0010};
        vecs[4] = '{enc_i(6'h08, 5'd3, 5'd9, 16'h8000),   1'b1, C_ADDI, 6'h08, 32'h300, 32'h999, 32'hFFFF_8000};
        vecs[5] = '{enc_i(6'h3F, 5'd1, 5'd2, 16'h1234),   1'b1, C_NONE, 6'h3F, 32'h100, 32'h200, 32'h0000_1234};
        vecs[6] = '{enc_r(5'd1, 5'd2, 5'd6),              1'b0, C_NONE, 6'h00, 32'h100, 32'h200, 32'h0000_3020};

        #3 Reset = 1'b0;
        tick();
        tick();
        chk("rst_valid", OutValid, 1'b0);
        chk("rst_ctrl", act_ctrl, C_NONE);
        chk("rst_aluop", ALUOp, 6'h00);
        chk("rst_pc", PCAddResult_out, 32'h0);
        chk("rst_sext", SignExtResult, 32'h0);
        chk("rst_stall", Stall_out, 1'b0);
        Reset = 1'b1;

        write_reg(5'd1, 32'h100);
        write_reg(5'd2, 32'h200);
        write_reg(5'd3, 32'h300);
        write_reg(5'd4, 32'h444);
        write_reg(5'd5, 32'h555);
        write_reg(5'd9, 32'h999);

        // Decode table.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].instr, vecs[i].in_valid);
            PCAddResult_in = 32'h1000 + 32'(4 * i);
            exp_q.push_back({vecs[i].in_valid, vecs[i].ctrl});
            #1;
            chk("tbl_stall", Stall_out, 1'b0);
            tick();
            begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("tbl_valid", OutValid, e[7]);
                chk("tbl_ctrl", act_ctrl, e[6:0]);
            end
            if (vecs[i].in_valid) begin
                chk("tbl_aluop", ALUOp, vecs[i].alu_op);
                chk("tbl_rd1", ReadData1, vecs[i].rd1);
                chk("tbl_rd2", ReadData2, vecs[i].rd2);
                chk("tbl_sext", SignExtResult, vecs[i].sext);
                chk("tbl_pc", PCAddResult_out, 32'h1000 + 32'(4 * i));
                chk("tbl_rs", rs, vecs[i].instr[25:21]);
                chk("tbl_rt", rt, vecs[i].instr[20:16]);
            end
        end

        // Load-use interlock cases.
        lw_then("lu_add", enc_r(5'd4, 5'd3, 5'd2), 1'b1, 5'd4);
        lw_then("lu_sw", enc_i(6'h2B, 5'd2, 5'd4, 16'd0), 1'b1, 5'd4);
        lw_then("lu_addi_rs", enc_i(6'h08, 5'd4, 5'd7, 16'd1), 1'b1, 5'd4);
        lw_then("lu_addi_none", enc_i(6'h08, 5'd9, 5'd7, 16'd1), 1'b0, 5'd4);
        lw_then("lu_addi_rt", enc_i(6'h08, 5'd9, 5'd4, 16'd1), 1'b0, 5'd4);
        lw_then("lu_r0", enc_r(5'd0, 5'd3, 5'd2), 1'b0, 5'd0);

        // Flush suppresses the load-use stall and loads a bubble.
        drive(enc_i(6'h23, 5'd1, 5'd4, 16'd8), 1'b1);
        tick();
        drive(enc_r(5'd4, 5'd3, 5'd2), 1'b1);
        Flush = 1'b1;
        #1;
        chk("flush_no_stall", Stall_out, 1'b0);
        tick();
        Flush = 1'b0;
        chk("flush_bubble_valid", OutValid, 1'b0);
        chk("flush_bubble_ctrl", act_ctrl, C_NONE);

        // Stall_in beats Flush; register file still written while held.
        drive(enc_i(6'h08, 5'd9, 5'd7, 16'd1), 1'b1);
        PCAddResult_in = 32'h2000;
        tick();
        drive(enc_r(5'd1, 5'd2, 5'd6), 1'b1);
        PCAddResult_in = 32'h3000;
        Stall_in = 1'b1;
        Flush = 1'b1;
        WriteRegister = 5'd10;
        WriteData = 32'hABCD;
        RegWrite_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_stall_out", Stall_out, 1'b1);
            tick();
            RegWrite_in = 1'b0;
            chk("hold_valid", OutValid, 1'b1);
            chk("hold_ctrl", act_ctrl, C_ADDI);
            chk("hold_rs", rs, 5'd9);
            chk("hold_pc", PCAddResult_out, 32'h2000);
        end
        Stall_in = 1'b0;
        #1;
        chk("flush_only_stall", Stall_out, 1'b0);
        tick();
        Flush = 1'b0;
        chk("late_flush_valid", OutValid, 1'b0);
        chk("late_flush_ctrl", act_ctrl, C_NONE);
        drive(enc_r(5'd10, 5'd0, 5'd11), 1'b1);
        tick();
        chk("write_during_stall", ReadData1, 32'hABCD);

        // Same-cycle write-back of r5 while add r6,r5,r0 is in decode.
        drive(enc_r(5'd5, 5'd0, 5'd6), 1'b1);
        WriteRegister = 5'd5;
        WriteData = 32'h1234;
        RegWrite_in = 1'b1;
        tick();
        RegWrite_in = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("bypass_rd1", ReadData1, 32'h1234);
`else
        chk("bypass_rd1", ReadData1, 32'h555);
`endif
        chk("bypass_rd2", ReadData2, 32'h0);
        tick();
        chk("after_wb_rd1", ReadData1, 32'h1234);

        // r0 is never written.
        drive(32'd0, 1'b0);
        write_reg(5'd0, 32'hDEAD);
        drive(enc_r(5'd0, 5'd0, 5'd6), 1'b1);
        WriteRegister = 5'd0;
        WriteData = 32'hBEEF;
        RegWrite_in = 1'b1;
        tick();
        RegWrite_in = 1'b0;
        chk("r0_same_cycle", ReadData1, 32'h0);
        tick();
        chk("r0_rd1", ReadData1, 32'h0);
        chk("r0_rd2", ReadData2, 32'h0);

        // Reset asserted between edges during a load-use stall.
        drive(enc_i(6'h23, 5'd1, 5'd4, 16'd8), 1'b1);
        tick();
        drive(enc_r(5'd4, 5'd3, 5'd2), 1'b1);
        #1;
        chk("pre_reset_stall", Stall_out, 1'b1);
        Reset = 1'b0;
        #1;
        chk("mid_reset_valid", OutValid, 1'b0);
        chk("mid_reset_ctrl", act_ctrl, C_NONE);
        chk("mid_reset_pc", PCAddResult_out, 32'h0);
        chk("mid_reset_rd1", ReadData1, 32'h0);
        chk("mid_reset_stall", Stall_out, 1'b0);
        Stall_in = 1'b1;
        #1;
        chk("reset_masks_stall_in", Stall_out, 1'b0);
        Stall_in = 1'b0;
        tick();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("post_reset_stall", Stall_out, 1'b0);
        tick();
        chk("post_reset_valid", OutValid, 1'b1);
        chk("post_reset_rs", rs, 5'd4);
        chk("post_reset_ctrl", act_ctrl, C_R);

        for (int r = 1; r < 32; r++) begin
            drive(enc_r(5'(r), 5'(r), 5'd0), 1'b1);
            tick();
            chk("cleared_rd1", ReadData1, 32'h0);
            chk("cleared_rd2", ReadData2, 32'h0);
        end

        // Final report.
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_id_pipe.md
STAGE_ID_PIPE -- requirements
Module: stage_ID_pipe

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the datapath width for PC, register data and sign-extended immediate, with a legal range of 16 to 64.
REQ-002 Parameter NREGS, default 32, SHALL set the register-file depth, a power of two from 8 to 32; REG_AW = clog2(NREGS).
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Inputs SHALL be: PCAddResult_in (DATA_W), Instruction (32), InValid (1), WriteRegister (REG_AW), WriteData (DATA_W), RegWrite_in (1), Stall_in (1, downstream hold) and Flush (1, squash the instruction in decode).
REQ-006 Registered outputs SHALL be: OutValid, RegWrite_out, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc (1 each); ALUOp (6); PCAddResult_out, ReadData1, ReadData2, SignExtResult (DATA_W each); rs, rt, rd (REG_AW each).
REQ-007 Output Stall_out, combinational, 1 bit, SHALL tell IF and decode to hold PC and Instruction.

Function
REQ-008 The block SHALL contain an NREGS x DATA_W register file; register 0 reads as 0 and ignores writes.
REQ-009 The register file SHALL write WriteData to WriteRegister on the rising edge when RegWrite_in=1 and WriteRegister!=0.
REQ-010 The register-index fields SHALL be rs=Instruction[21+:REG_AW], rt=Instruction[16+:REG_AW], rd=Instruction[11+:REG_AW], and reads SHALL be combinational.
REQ-011 Decode SHALL set ALUOp=Instruction[31:26] for every opcode and drive the 1-bit controls per opcode as follows:
- 000000 (R): RegDst, RegWrite.
- 100011 (lw): ALUSrc, MemtoReg, RegWrite, MemRead.
- 101011 (sw): ALUSrc, MemWrite.
- 000100 (beq): Branch.
- 001000 (addi): ALUSrc, RegWrite.
- Any other opcode: all 1-bit controls 0.
REQ-012 SignExtResult SHALL equal Instruction[15:0] sign-extended to DATA_W bits.
REQ-013 The ID/EX register SHALL capture decode results with 1-cycle latency; OutValid SHALL follow the captured InValid.
REQ-014 A load-use hazard SHALL be OutValid & MemRead & rt_out!=0 & InValid & (rt_out==rs_in, or rt_out==rt_in when the opcode is R, sw or beq).
REQ-015 On a load-use hazard, Stall_out SHALL be 1 and the ID/EX register SHALL load a bubble: OutValid=0 and all 1-bit controls 0.
REQ-016 A stall SHALL last exactly one cycle per hazard, because the bubble clears the MemRead condition.
REQ-017 Update priority SHALL be Stall_in (hold all ID/EX contents) > Flush (load bubble) > load-use (bubble) > normal capture.
REQ-018 Stall_out SHALL equal Stall_in | (load-use & ~Flush).
REQ-019 Flush SHALL not assert Stall_out.
REQ-020 While Stall_in=1, the register file SHALL still accept writes.
REQ-021 InValid=0 SHALL capture a bubble and never raise a hazard.

Reset
REQ-022 Reset low SHALL immediately clear all ID/EX outputs to 0, including OutValid.
REQ-023 Reset SHALL clear every register-file entry to 0.
REQ-024 Reset SHALL force Stall_out to 0.
REQ-025 Reset asserted mid-stall SHALL abandon the stall; the first edge after release SHALL capture normally.

Configuration
REQ-026 When ID_WB_BYPASS_EN is defined, a same-cycle write (RegWrite_in=1, WriteRegister!=0) matching rs or rt SHALL make the corresponding captured ReadData1/ReadData2 equal WriteData.
REQ-027 When ID_WB_BYPASS_EN is undefined, the pre-write register value SHALL be captured, and software must separate a dependent instruction from its producer's WB by one cycle.

Verification
REQ-028 The bench SHALL check bypass: write r5=0x1234 and present add r6,r5,r0 in the same cycle. With bypass on, ReadData1=0x1234; with bypass off, ReadData1=old r5.
REQ-029 The bench SHALL check load-use: issue lw r4,8(r1), then add r2,r4,r3. Stall_out=1 for one cycle, one bubble (OutValid=0) appears, then add is captured with rs=4.
REQ-030 The bench SHALL check the sw dependence: issue lw r4, then sw r4,0(r2), which rt-matches. The bench SHALL also check addi r7,r4,1 following lw r4, where the rs-match stalls; an lw r4 followed by addi r7,r9,1 SHALL not stall.
REQ-031 The bench SHALL check stall priority: assert Stall_in and Flush together for 3 cycles. ID/EX outputs stay unchanged, Stall_out=1, and the flush takes effect after Stall_in drops.
REQ-032 The bench SHALL check reset: assert Reset low mid-stall between clock edges. Outputs go to 0 and Stall_out goes to 0 before the next edge, and r1..r31 subsequently read 0.
REQ-033 The bench SHALL check edge cases: a write to r0 is ignored (r0 reads 0); Instruction[15:0]=0x8000 gives SignExtResult=0xFFFF8000 at DATA_W=32; an unknown opcode 111111 gives ALUOp=6'h3F with all controls 0.
